// File: rtl/placement_pkg.sv
// Shared definitions for the placement engine and its readback scanner:
// grid geometry, data width, empty-cell marker and FSM state encoding.
package placement_pkg;

   localparam int GRID_N = 7;
   localparam int DATA_W = 32;
   localparam logic signed [DATA_W-1:0] EMPTY_CELL = -1;

   typedef enum logic [3:0] {
      IDLE,
      RD_GRID,
      WAIT_GRID,
      CHK,
      RD_POS,
      WAIT_POS,
      CMP,
      EMIT,
      NEXT,
      FIN
   } place_state_t;

endpackage

// File: rtl/placement_readback_grid_scan_ctr.sv
// Cell index plus (x,y) walked incrementally, y fastest, so the scanner
// never has to form x*N+y or divide an index back into coordinates.
module grid_scan_ctr
   import placement_pkg::*;
#(
   parameter int N = GRID_N
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              step,
   output logic [DATA_W-1:0] idx,
   output logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y,
   output logic              last
);

   localparam logic [DATA_W-1:0] EDGE = DATA_W'(N - 1);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         idx <= '0;
         x   <= '0;
         y   <= '0;
      end else if (step) begin
         idx <= idx + 1'b1;
         if (y == EDGE) begin
            y <= '0;
            x <= x + 1'b1;
         end else begin
            y <= y + 1'b1;
         end
      end
   end

   assign last = (x == EDGE) && (y == EDGE);

endmodule

// File: rtl/placement_readback.sv
// Walks every grid cell, reads back the node placed there and emits
// (node, x, y) records. Define PLACE_RDBK_CHECK_EN to also cross-check the
// node's stored position against the scanned cell and count mismatches.
module placement_readback
   import placement_pkg::*;
#(
   parameter int N         = GRID_N,
   parameter int MAX_NODES = 128
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     reGrid,
   output logic [DATA_W-1:0]        addrGrid,
   input  logic signed [DATA_W-1:0] doutGrid,
   output logic                     rePX,
   output logic [DATA_W-1:0]        addrPX,
   output logic                     rePY,
   output logic [DATA_W-1:0]        addrPY,
   input  logic signed [DATA_W-1:0] doutPX,
   input  logic signed [DATA_W-1:0] doutPY,
   output logic                     rec_valid,
   input  logic                     rec_ready,
   output logic signed [DATA_W-1:0] rec_node,
   output logic signed [DATA_W-1:0] rec_x,
   output logic signed [DATA_W-1:0] rec_y,
   output logic                     done,
   output logic                     busy,
   output logic [DATA_W-1:0]        node_count,
   output logic [DATA_W-1:0]        err_count
);

   localparam logic signed [DATA_W-1:0] MAX_ID = DATA_W'(MAX_NODES);

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   place_state_t state, state_nxt;

   logic signed [DATA_W-1:0] node_q;
   logic [DATA_W-1:0]        idx, x, y;
   logic                     last, clear, step;
   logic                     id_ok, cell_bad, err_hit;

   grid_scan_ctr #(.N(N)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .step  (step),
      .idx   (idx),
      .x     (x),
      .y     (y),
      .last  (last)
   );

   assign id_ok    = (node_q >= 0) && (node_q < MAX_ID);
   assign cell_bad = (node_q != EMPTY_CELL) && !id_ok;

`ifdef PLACE_RDBK_CHECK_EN
   logic signed [DATA_W-1:0] px_q, py_q;
   logic                     pos_miss;

   assign pos_miss = (px_q != $signed(x)) || (py_q != $signed(y));
   assign err_hit  = ((state == CHK) && cell_bad) || ((state == CMP) && pos_miss);

   always_ff @(posedge clk) begin
      if (state == WAIT_POS) begin
         px_q <= doutPX;
         py_q <= doutPY;
      end
   end
`else
   logic pos_unused;
   assign pos_unused = ^{doutPX, doutPY};
   assign err_hit    = (state == CHK) && cell_bad;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         node_count <= '0;
         err_count  <= '0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && start) begin
            node_count <= '0;
            err_count  <= '0;
         end else begin
            if (err_hit)
               err_count <= sat_inc(err_count);
            if ((state == EMIT) && rec_ready)
               node_count <= sat_inc(node_count);
         end
      end
   end

   // Grid data arrives one wait state after the strobe; capture it on the way into CHK.
   always_ff @(posedge clk) begin
      if (state == WAIT_GRID)
         node_q <= doutGrid;
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      step      = 1'b0;
      reGrid    = 1'b0;
      addrGrid  = '0;
      rePX      = 1'b0;
      rePY      = 1'b0;
      addrPX    = '0;
      addrPY    = '0;
      rec_valid = 1'b0;
      rec_node  = '0;
      rec_x     = '0;
      rec_y     = '0;
      done      = 1'b0;
      busy      = (state != IDLE);

      case (state)
         IDLE: begin
            if (start) begin
               clear     = 1'b1;
               state_nxt = RD_GRID;
            end
         end
         RD_GRID: begin
            reGrid    = 1'b1;
            addrGrid  = idx;
            state_nxt = WAIT_GRID;
         end
         WAIT_GRID: state_nxt = CHK;
         CHK: begin
            if ((node_q == EMPTY_CELL) || !id_ok)
               state_nxt = NEXT;
            else
`ifdef PLACE_RDBK_CHECK_EN
               state_nxt = RD_POS;
`else
               state_nxt = EMIT;
`endif
         end
         RD_POS: begin
`ifdef PLACE_RDBK_CHECK_EN
            rePX   = 1'b1;
            rePY   = 1'b1;
            addrPX = node_q;
            addrPY = node_q;
`endif
            state_nxt = WAIT_POS;
         end
         WAIT_POS: state_nxt = CMP;
         CMP:      state_nxt = EMIT;
         // Payload comes from registers that cannot change while EMIT waits.
         EMIT: begin
            rec_valid = 1'b1;
            rec_node  = node_q;
            rec_x     = $signed(x);
            rec_y     = $signed(y);
            if (rec_ready)
               state_nxt = NEXT;
         end
         NEXT: begin
            if (last) begin
               state_nxt = FIN;
            end else begin
               step      = 1'b1;
               state_nxt = RD_GRID;
            end
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_placement_readback.sv
// Randomised scoreboard bench for placement_readback; records are predicted
// from the grid/position contents by walking cells in address order.
module tb_placement_readback;

   localparam int N     = 7;
   localparam int MAXN  = 128;
   localparam int CELLS = N * N;
`ifdef PLACE_RDBK_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   typedef struct {
      int node;
      int x;
      int y;
   } rec_t;

   logic               clk = 1'b0;
   logic               reset, start, rec_ready;
   logic               reGrid, rePX, rePY, rec_valid, done, busy;
   logic [31:0]        addrGrid, addrPX, addrPY, node_count, err_count;
   logic signed [31:0] doutGrid, doutPX, doutPY, rec_node, rec_x, rec_y;

   int grid_mem [CELLS];
   int posx_mem [MAXN];
   int posy_mem [MAXN];

   rec_t exp_q[$];
   rec_t prev;
   bit   have_prev;
   int   exp_nodes, exp_err, exp_pos;
   int   done_cnt, stall_cnt, pos_rd_cnt, hold_left, ready_mode;
   int   vectors, miscompares;

   placement_readback #(.N(N), .MAX_NODES(MAXN)) dut (
      .clk(clk), .reset(reset), .start(start),
      .reGrid(reGrid), .addrGrid(addrGrid), .doutGrid(doutGrid),
      .rePX(rePX), .addrPX(addrPX), .rePY(rePY), .addrPY(addrPY),
      .doutPX(doutPX), .doutPY(doutPY),
      .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_node(rec_node), .rec_x(rec_x), .rec_y(rec_y),
      .done(done), .busy(busy), .node_count(node_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Registered-read memories: one wait state between strobe and data.
   always @(posedge clk) begin
      if (reGrid) doutGrid <= (addrGrid < CELLS) ? grid_mem[addrGrid[5:0]] : 0;
      if (rePX)   doutPX   <= (addrPX < MAXN) ? posx_mem[addrPX[6:0]] : 0;
      if (rePY)   doutPY   <= (addrPY < MAXN) ? posy_mem[addrPY[6:0]] : 0;
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      rec_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 2 && rec_valid && hold_left > 0) begin
            rec_ready = 1'b0;
            hold_left--;
         end else if (ready_mode == 1) begin
            rec_ready = 1'($urandom_range(0, 1));
         end else begin
            rec_ready = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted record.
   initial begin
      rec_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            have_prev = 1'b0;
         end else begin
            if (done) done_cnt++;
            if (rePX || rePY) pos_rd_cnt++;
            if (rec_valid) begin
               if (have_prev) begin
                  chk("stable_node", rec_node, prev.node);
                  chk("stable_x", rec_x, prev.x);
                  chk("stable_y", rec_y, prev.y);
               end
               if (rec_ready) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_record_node", rec_node, -99);
                  end else begin
                     e = exp_q.pop_front();
                     chk("rec_node", rec_node, e.node);
                     chk("rec_x", rec_x, e.x);
                     chk("rec_y", rec_y, e.y);
                  end
                  have_prev = 1'b0;
               end else begin
                  prev      = '{node: rec_node, x: rec_x, y: rec_y};
                  have_prev = 1'b1;
                  stall_cnt++;
               end
            end
         end
      end
   end

   task automatic build_model();
      exp_q.delete();
      exp_nodes = 0;
      exp_err   = 0;
      exp_pos   = 0;
      for (int a = 0; a < CELLS; a++) begin
         int g, cx, cy;
         g  = grid_mem[a];
         cx = a / N;
         cy = a % N;
         if (g == -1) continue;
         if (g < -1 || g >= MAXN) begin
            exp_err++;
            continue;
         end
         exp_q.push_back('{node: g, x: cx, y: cy});
         exp_nodes++;
         if (CHECK_EN) begin
            exp_pos++;
            if (posx_mem[g] != cx || posy_mem[g] != cy) exp_err++;
         end
      end
   endtask

   task automatic clear_grid();
      for (int a = 0; a < CELLS; a++) grid_mem[a] = -1;
   endtask

   task automatic random_grid();
      for (int a = 0; a < CELLS; a++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 5)       grid_mem[a] = -1;
         else if (r < 8)  grid_mem[a] = int'($urandom_range(0, MAXN - 1));
         else if (r == 8) grid_mem[a] = MAXN + int'($urandom_range(0, 50));
         else             grid_mem[a] = -2 - int'($urandom_range(0, 5));
      end
      for (int i = 0; i < MAXN; i++) begin
         posx_mem[i] = int'($urandom_range(0, N - 1));
         posy_mem[i] = int'($urandom_range(0, N - 1));
      end
      for (int a = 0; a < CELLS; a++) begin
         if (grid_mem[a] >= 0 && grid_mem[a] < MAXN && $urandom_range(0, 1) == 1) begin
            posx_mem[grid_mem[a]] = a / N;
            posy_mem[grid_mem[a]] = a % N;
         end
      end
   endtask

   task automatic run_scan(input int mode, input bit want_latency);
      int cyc;
      build_model();
      done_cnt   = 0;
      stall_cnt  = 0;
      pos_rd_cnt = 0;
      hold_left  = 5;
      ready_mode = mode;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 1;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", int'(done), 1);
      if (want_latency) chk("start_to_done_cycles", cyc + 1, 4 * N * N + 2);
      repeat (4) @(negedge clk);
      chk("node_count", node_count, exp_nodes);
      chk("err_count", err_count, exp_err);
      chk("records_left", exp_q.size(), 0);
      chk("done_pulses", done_cnt, 1);
      chk("busy_after_done", int'(busy), 0);
      chk("pos_reads", pos_rd_cnt, exp_pos);
      if (mode == 2) chk("stall_cycles", stall_cnt, 5);
      ready_mode = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      ready_mode  = 0;
      have_prev   = 1'b0;
      reset       = 1'b1;
      start       = 1'b0;
      clear_grid();
      for (int i = 0; i < MAXN; i++) begin
         posx_mem[i] = 0;
         posy_mem[i] = 0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_strobes", int'({reGrid, rePX, rePY}), 0);
      chk("rst_addrs", int'(addrGrid | addrPX | addrPY), 0);
      chk("rst_rec_valid", int'(rec_valid), 0);
      chk("rst_payload", int'(rec_node | rec_x | rec_y), 0);
      chk("rst_busy_done", int'({busy, done}), 0);
      chk("rst_node_count", node_count, 0);
      chk("rst_err_count", err_count, 0);

      // Empty grid.
      run_scan(0, 1'b1);

      // Single node at cell 10 = (1,3), stored position matching.
      grid_mem[10] = 3;
      posx_mem[3]  = 1;
      posy_mem[3]  = 3;
      run_scan(0, 1'b0);

      // Same node, stored y disagrees with the scan.
      posy_mem[3] = 4;
      run_scan(0, 1'b0);

      // Two nodes, back-pressure on the first record.
      clear_grid();
      grid_mem[5]  = 7;
      grid_mem[20] = 2;
      posx_mem[7]  = 0;
      posy_mem[7]  = 5;
      posx_mem[2]  = 2;
      posy_mem[2]  = 6;
      run_scan(2, 1'b0);

      // Out-of-range ids alongside the largest legal id in the last row.
      clear_grid();
      grid_mem[3]    = 200;
      grid_mem[40]   = -5;
      grid_mem[45]   = MAXN - 1;
      grid_mem[48]   = MAXN;
      posx_mem[MAXN - 1] = 6;
      posy_mem[MAXN - 1] = 3;
      run_scan(1, 1'b0);

      for (int t = 0; t < 4; t++) begin
         random_grid();
         run_scan(1, 1'b0);
      end

      // Reset part-way through a scan, then a clean rescan.
      random_grid();
      build_model();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (60) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      done_cnt = 0;
      reset    = 1'b0;
      exp_q.delete();
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_rec_valid", int'(rec_valid), 0);
      chk("midrst_counts", int'(node_count | err_count), 0);
      repeat (3) @(negedge clk);
      chk("midrst_no_done", done_cnt, 0);
      run_scan(0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/placement_readback.md
PLACEMENT_READBACK -- requirements
Module: placement_readback

Interface
REQ-001 Parameter N, default 7: grid side; the grid holds N*N cells, and cell address = x*N+y.
REQ-002 Parameter MAX_NODES, default 128: node-id bound; pos memory depth.
REQ-003 clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a scan when idle, ignored otherwise.
REQ-006 reGrid, addrGrid  output  1, 32  grid read strobe and cell address.
REQ-007 doutGrid  input  32 signed  grid data: node id, or -1 for an empty cell.
REQ-008 rePX/addrPX, rePY/addrPY  output  1, 32 each  position memory read strobes and addresses.
REQ-009 doutPX, doutPY  input  32 signed each  stored x and y of the addressed node.
REQ-010 rec_valid, rec_ready  output, input  1 each  record stream handshake.
REQ-011 rec_node, rec_x, rec_y  output  32 signed each  record payload: node id, x, y.
REQ-012 done  output  1  high one cycle when a scan ends.
REQ-013 busy  output  1  high from the cycle after start until done.
REQ-014 node_count, err_count  output  32 each  occupied cells emitted; mismatches found.

Function
REQ-015 Memory reads have 1-cycle latency: strobe and address registered at edge t; dout valid and sampled at edge t+2, i.e. one wait state.
REQ-016 FSM states: IDLE, RD_GRID, WAIT_GRID, CHK, RD_POS, WAIT_POS, CMP, EMIT, NEXT, FIN.
REQ-017 IDLE -> RD_GRID on start, clearing the cell index, node_count and err_count.
REQ-018 RD_GRID issues reGrid=1 with addrGrid = cell index, then goes to WAIT_GRID.
REQ-019 WAIT_GRID -> CHK; CHK latches doutGrid.
REQ-020 CHK goes to NEXT when the latched value is -1; otherwise it goes to RD_POS.
REQ-021 RD_POS issues rePX/rePY at the node address, then goes WAIT_POS -> CMP.
REQ-022 In CMP, stored (doutPX,doutPY) != scan (x,y) increments err_count, saturating at 2^32-1; CMP -> EMIT.
REQ-023 In EMIT, rec_valid=1 and the payload is (node, scan x, scan y); the payload holds stable while rec_ready=0.
REQ-024 EMIT -> NEXT on rec_valid && rec_ready, incrementing node_count.
REQ-025 A node id >= MAX_NODES or < -1 counts as an error, skips RD_POS and is not emitted.
REQ-026 NEXT: if the cell index is N*N-1, go to FIN; otherwise increment the index and go to RD_GRID. The scan x,y wrap with y first (y=N-1 -> y=0, x+1).
REQ-027 FIN pulses done=1 for one cycle -> IDLE; the counts hold until the next start.
REQ-028 Strobes are single-cycle and default to 0 in every other cycle; no write ports exist.

Reset
REQ-029 Reset forces IDLE.
REQ-030 Reset drives all strobes, rec_valid, busy, done, node_count, err_count, addresses and payload to 0.
REQ-031 Reset mid-scan abandons the scan without a done pulse.

Configuration
REQ-032 With PLACE_RDBK_CHECK_EN defined: the RD_POS, WAIT_POS and CMP path runs as specified.
REQ-033 Without PLACE_RDBK_CHECK_EN: CHK goes directly to EMIT, the pos strobes stay 0, err_count counts only the invalid ids of REQ-025, and a scan of an empty grid takes 4*N*N+2 cycles from start to done.

Structure
REQ-034 Package placement_pkg holds N, EMPTY_CELL = -1, the data width 32, and the FSM state encoding shared with the placement engine.
REQ-035 One sub-module, grid_scan_ctr, holds the cell index and x,y with clear/step/last outputs, so that no multiplier is needed.

Verification
REQ-036 All-empty 7x7 grid, start pulse -> no records; node_count=0, err_count=0; done exactly once.
REQ-037 Grid cell 10 = node 3, posX[3]=1, posY[3]=3, rec_ready=1 -> one record (3,1,3); node_count=1, err_count=0.
REQ-038 Same stimulus but posY[3]=4 -> record (3,1,3) still emitted; err_count=1 with CHECK_EN, err_count=0 without it.
REQ-039 Two occupied cells with rec_ready held low for 5 cycles at the first record -> payload stable for all 5 cycles; records arrive in address order.
REQ-040 Reset asserted mid-scan, then start -> a full fresh scan with correct counts and no stale done pulse.
